// File: rtl/tinker_exec_unit.sv
// Registered Tinker execute stage with valid/ready handshakes on both sides.
// Define TINKER_EXEC_DIV_EN to build the iterative restoring divider (op 0x1d).
module tinker_exec_unit #(
    parameter int WIDTH     = 64,
    parameter int LIT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [LIT_WIDTH-1:0] lit,
    input  logic [4:0]           rd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [4:0]           rd_out,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_lit_ext;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    logic             w_use_lit;
    logic             w_big_shift;
    logic             w_ill;
    logic             w_dz;
    logic             w_div_start;
    logic             w_accept;
    logic             w_drain;
    logic             w_idle;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [4:0]       w_div_rd;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rd_out;
    logic             r_div_zero;
    logic             r_illegal;

    assign w_lit_ext   = {{(WIDTH-LIT_WIDTH){1'b0}}, lit};
    assign w_b         = w_use_lit ? w_lit_ext : b;
    assign w_big_shift = |w_b[WIDTH-1:SHW];
    assign w_accept    = in_valid && in_ready;
    assign w_drain     = r_out_valid && out_ready;
    assign in_ready    = w_idle && (!r_out_valid || out_ready);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign rd_out    = r_rd_out;
    assign div_zero  = r_div_zero;
    assign illegal   = r_illegal;

    // Immediate forms take the zero-extended literal as operand B.
    always_comb begin
        case (op)
            5'h05, 5'h07, 5'h12, 5'h19, 5'h1b: w_use_lit = 1'b1;
            default:                           w_use_lit = 1'b0;
        endcase
    end

    // Single-cycle result and flags for the op being offered.
    always_comb begin
        w_res       = {WIDTH{1'b0}};
        w_ill       = 1'b0;
        w_dz        = 1'b0;
        w_div_start = 1'b0;
        case (op)
            5'h00:        w_res = a & w_b;
            5'h01:        w_res = a | w_b;
            5'h02:        w_res = a ^ w_b;
            5'h03:        w_res = ~a;
            5'h04, 5'h05: w_res = w_big_shift ? {WIDTH{1'b0}} : (a >> w_b[SHW-1:0]);
            5'h06, 5'h07: w_res = w_big_shift ? {WIDTH{1'b0}} : (a << w_b[SHW-1:0]);
            5'h11:        w_res = a;
            5'h12:        w_res = w_b;
            5'h18, 5'h19: w_res = a + w_b;
            5'h1a, 5'h1b: w_res = a - w_b;
            5'h1c:        w_res = a * w_b;
`ifdef TINKER_EXEC_DIV_EN
            5'h1d: begin
                if (w_b == {WIDTH{1'b0}}) begin
                    w_res = {WIDTH{1'b1}};
                    w_dz  = 1'b1;
                end else begin
                    w_div_start = 1'b1;
                end
            end
`endif
            default:      w_ill = 1'b1;
        endcase
    end

`ifdef TINKER_EXEC_DIV_EN
    localparam int CW = SHW + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [4:0]       r_div_rd;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;

    // r_quo starts as the dividend and fills with quotient bits from the LSB end.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_dvs};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_div_quo   = {r_quo[WIDTH-2:0], w_qbit};
    assign w_div_rd    = r_div_rd;
    assign w_idle      = (r_state == S_IDLE);
    assign w_div_done  = (r_state == S_DIV) && (r_cnt == CW'(1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_div_start) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divider datapath: one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= {CW{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_div_rd <= 5'd0;
        end else if (w_accept && w_div_start) begin
            r_cnt    <= CW'(WIDTH);
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= a;
            r_dvs    <= w_b;
            r_div_rd <= rd_in;
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_qbit ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
            r_quo <= w_div_quo;
        end
    end
`else
    assign w_idle     = 1'b1;
    assign w_div_done = 1'b0;
    assign w_div_quo  = {WIDTH{1'b0}};
    assign w_div_rd   = 5'd0;
`endif

    // Output register; a drain and a new load on the same edge keep out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_rd_out    <= 5'd0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept && !w_div_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_rd_out    <= rd_in;
            r_div_zero  <= w_dz;
            r_illegal   <= w_ill;
        end else if (w_div_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_div_quo;
            r_rd_out    <= w_div_rd;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
